// File: rtl/dsam_stream_encoder.sv
// Flow-controlled DSAM stream encoder: per-channel frame delta, sign-magnitude
// conversion and XOR chaining of magnitudes, with valid/ready on both sides.
module dsam_stream_encoder #(
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_CHANNELS = 256,
    parameter int CHAN_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [CHAN_WIDTH-1:0] channels,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int PTR_W = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;
    localparam logic [CHAN_WIDTH-1:0] MAX_CH = CHAN_WIDTH'(MAX_CHANNELS);
    localparam logic [1:0] MODE_BYPASS  = 2'd0;
    localparam logic [1:0] MODE_DSM     = 2'd1;
    localparam logic [1:0] MODE_DEFAULT = 2'd3;

    logic [DATA_WIDTH-1:0] hist_q [MAX_CHANNELS];

    logic [1:0]            cfg_mode_q, cfg_mode_d;
    logic [CHAN_WIDTH-1:0] cfg_channels_q, cfg_channels_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [CHAN_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [DATA_WIDTH-2:0] corr_q, corr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  accept;
    logic [CHAN_WIDTH-1:0] ch_clamped;
    logic [1:0]            eff_mode;
    logic [CHAN_WIDTH-1:0] eff_ch;
    logic [PTR_W-1:0]      eff_wptr;
    logic [CHAN_WIDTH-1:0] eff_wcnt;
    logic [DATA_WIDTH-2:0] eff_corr;
    logic [DATA_WIDTH-1:0] hist_rd;
    logic                  warm;
    logic [DATA_WIDTH-1:0] diff;
    logic                  sign;
    logic [DATA_WIDTH-2:0] mag;
    logic [DATA_WIDTH-2:0] corr_next;
    logic [DATA_WIDTH-1:0] word;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        ch_clamped = ((channels == '0) || (channels > MAX_CH)) ? MAX_CH : channels;
        // A sample accepted together with clear already sees the fresh stream state.
        eff_mode = clear ? mode       : cfg_mode_q;
        eff_ch   = clear ? ch_clamped : cfg_channels_q;
        eff_wptr = clear ? '0         : wptr_q;
        eff_wcnt = clear ? '0         : wcnt_q;
        eff_corr = clear ? '0         : corr_q;

        hist_rd   = hist_q[eff_wptr];
        warm      = (eff_wcnt == eff_ch);
        diff      = (eff_mode[0] && warm) ? (in_data - hist_rd) : in_data;
        sign      = diff[DATA_WIDTH-1];
        mag       = sign ? ~diff[DATA_WIDTH-2:0] : diff[DATA_WIDTH-2:0];
        corr_next = mag ^ eff_corr;

        case (eff_mode)
            MODE_BYPASS: word = in_data;
            MODE_DSM:    word = {sign, mag};
            default:     word = {sign, corr_next};
        endcase
    end

    always_comb begin
        cfg_mode_d     = cfg_mode_q;
        cfg_channels_d = cfg_channels_q;
        wptr_d         = wptr_q;
        wcnt_d         = wcnt_q;
        corr_d         = corr_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;

        if (clear) begin
            cfg_mode_d     = mode;
            cfg_channels_d = ch_clamped;
            wptr_d         = '0;
            wcnt_d         = '0;
            corr_d         = '0;
        end

        if (accept) begin
            wptr_d = (CHAN_WIDTH'(eff_wptr) == eff_ch - CHAN_WIDTH'(1)) ? '0 : eff_wptr + PTR_W'(1);
            wcnt_d = warm ? eff_wcnt : eff_wcnt + CHAN_WIDTH'(1);
            if (eff_mode[1]) begin
                corr_d = corr_next;
            end
            out_valid_d = 1'b1;
            out_data_d  = word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // History needs no reset: entries are only trusted once wcnt says they were rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_q[eff_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_mode_q     <= MODE_DEFAULT;
            cfg_channels_q <= MAX_CH;
            wptr_q         <= '0;
            wcnt_q         <= '0;
            corr_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else begin
            cfg_mode_q     <= cfg_mode_d;
            cfg_channels_q <= cfg_channels_d;
            wptr_q         <= wptr_d;
            wcnt_q         <= wcnt_d;
            corr_q         <= corr_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
        end
    end
endmodule

// File: tb/tb_dsam_stream_encoder.sv
// Directed bench for dsam_stream_encoder: hand-computed vectors per mode,
// backpressure, clear coincident with accept, and asynchronous reset.
module tb_dsam_stream_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [8:0]  channels = 9'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    dsam_stream_encoder #(.DATA_WIDTH(16), .MAX_CHANNELS(256), .CHAN_WIDTH(9)) dut (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode), .channels(channels),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One accepted sample: drive before the edge, sample 1 time unit after it.
    task automatic send(input logic clr, input logic [1:0] md, input logic [8:0] ch,
                        input logic [15:0] d, input logic [15:0] exp, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; clear = clr; mode = md; channels = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        $display("txn %s in=%h out=%h", tag, d, out_data);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        check(tag, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #9 reset = 1'b1;

        // Mode 0 bypass
        send(1'b1, 2'd0, 9'd0, 16'h1234, 16'h1234, "m0");
        idle_cycle("m0_drain");

        // Mode 3, two channels
        send(1'b1, 2'd3, 9'd2, 16'd10, 16'h000A, "m3_s0");
        send(1'b0, 2'd3, 9'd2, 16'd20, 16'h001E, "m3_s1");
        send(1'b0, 2'd3, 9'd2, 16'd15, 16'h001B, "m3_s2");
        send(1'b0, 2'd3, 9'd2, 16'd25, 16'h001E, "m3_s3");

        // Mode 1, one channel: 3-5 = 0xFFFE -> sign 1, mag 1
        send(1'b1, 2'd1, 9'd1, 16'h0005, 16'h0005, "m1_s0");
        send(1'b0, 2'd1, 9'd1, 16'h0003, 16'h8001, "m1_s1");

        // Mode 2, one channel: no delta even when warm
        send(1'b1, 2'd2, 9'd1, 16'h0005, 16'h0005, "m2_s0");
        send(1'b0, 2'd2, 9'd1, 16'h0003, 16'h0006, "m2_s1");
        send(1'b0, 2'd2, 9'd1, 16'hFFFE, 16'h8007, "m2_s2");

        // channels=0 and channels>MAX clamp to 256, so no delta on the 2nd sample
        send(1'b1, 2'd1, 9'd0, 16'h0005, 16'h0005, "clamp0_s0");
        send(1'b0, 2'd1, 9'd0, 16'h0003, 16'h0003, "clamp0_s1");
        send(1'b1, 2'd1, 9'd300, 16'h0005, 16'h0005, "clamp300_s0");
        send(1'b0, 2'd1, 9'd300, 16'h0003, 16'h0003, "clamp300_s1");

        // Backpressure: hold out_ready low 3 cycles with sample 15 waiting
        send(1'b1, 2'd3, 9'd2, 16'd10, 16'h000A, "bp_s0");
        send(1'b0, 2'd3, 9'd2, 16'd20, 16'h001E, "bp_s1");
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd15; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {16'd0, out_data}, 32'h001E);
            $display("txn bp_stall cycle=%0d out=%h", i, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_s2_data", {16'd0, out_data}, 32'h001B);
        $display("txn bp_s2 in=000f out=%h", out_data);
        send(1'b0, 2'd3, 9'd2, 16'd25, 16'h001E, "bp_s3");
        idle_cycle("bp_drain");

        // Clear coincident with an accept
        send(1'b1, 2'd3, 9'd2, 16'd10, 16'h000A, "clr_s0");
        send(1'b0, 2'd3, 9'd2, 16'd20, 16'h001E, "clr_s1");
        send(1'b0, 2'd3, 9'd2, 16'd15, 16'h001B, "clr_s2");
        send(1'b1, 2'd3, 9'd2, 16'd40, 16'h0028, "clr_s3");
        send(1'b0, 2'd3, 9'd2, 16'd50, 16'h001A, "clr_s4");

        // Asynchronous reset mid-stream, after switching to mode 1
        send(1'b1, 2'd1, 9'd1, 16'h0100, 16'h0100, "pre_rst");
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data", {16'd0, out_data}, 32'd0);
        #2 reset = 1'b1;
        // Defaults restored: mode 3, 256 channels, corr 0 -> 7, then 9^7
        send(1'b0, 2'd0, 9'd0, 16'd7, 16'h0007, "post_rst_s0");
        send(1'b0, 2'd0, 9'd0, 16'd9, 16'h000E, "post_rst_s1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
